// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : viterbi_pkg
// Purpose : Shared constants and state encoding for the decoder BER checker.
// Revision: 1.0 - initial release
// ============================================================================
package viterbi_pkg;

  localparam int DEF_CNT_W  = 16;
  // Depth of the reference-bit delay line feeding the checker.
  localparam int PIPE_DEPTH = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t FILL  = 2'd1;
  localparam state_t COUNT = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Up-counter with synchronous clear that sticks at all-ones.
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/viterbi_ber_checker.sv
`default_nettype none
// ============================================================================
// Module  : viterbi_ber_checker
// Purpose : Scores decoded bits against the delayed reference over a window.
//           Define BER_FIRST_ERR_EN to add first-mismatch index capture.
// Revision: 1.0 - initial release
// ============================================================================
module viterbi_ber_checker
  import viterbi_pkg::*;
#(
  parameter int LAT    = PIPE_DEPTH,
  parameter int WINDOW = 1024,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             ref_bit,
  input  logic             dec_bit,
  input  logic             dec_valid,
  output logic             busy,
  output logic             done,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
`ifdef BER_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld
`endif
);

  // The shared fill/bit counter must be wide enough to reach LAT as well.
  localparam int FILL_W = $clog2(LAT + 1);
  localparam int CW     = (CNT_W > FILL_W) ? CNT_W : FILL_W;

  localparam logic [CW-1:0] C_FILL_LAST   = CW'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [CW-1:0] C_WIN_LAST    = CW'(WINDOW - 1);
  localparam state_t        C_START_STATE = (LAT == 0) ? COUNT : FILL;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_busy;
  logic            r_done;
  logic            r_err_pulse;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_pulse_nxt;
  logic [CW-1:0]   w_cnt;

  logic w_start_ok;
  logic w_score;
  logic w_mismatch;
  logic w_fill_end;

  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_score    = (r_state == COUNT) && dec_valid;
  assign w_mismatch = ref_bit ^ dec_bit;
  assign w_fill_end = (r_state == FILL) && (w_cnt == C_FILL_LAST);

  // Counts FILL cycles first, then is cleared and reused as the bit count.
  sat_counter #(.W(CW)) u_bit_counter (
    .clock (clock),
    .reset (reset),
    .clr   (w_start_ok || w_fill_end),
    .inc   ((r_state == FILL) || w_score),
    .count (w_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_counter (
    .clock (clock),
    .reset (reset),
    .clr   (w_start_ok),
    .inc   (w_score && w_mismatch),
    .count (err_cnt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = C_START_STATE;
      FILL:       if (w_fill_end) w_state_nxt = COUNT;
      COUNT:      if (w_score && (w_cnt == C_WIN_LAST)) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt  = (w_state_nxt == FILL) || (w_state_nxt == COUNT);
    w_done_nxt  = (w_state_nxt == DONE);
    w_pulse_nxt = w_score && w_mismatch;
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err_pulse = r_err_pulse;
  assign bit_cnt   = ((r_state == COUNT) || (r_state == DONE)) ? w_cnt[CNT_W-1:0] : '0;

`ifdef BER_FIRST_ERR_EN
  logic [CNT_W-1:0] r_first_idx;
  logic             r_first_vld;

  always_ff @(posedge clock) begin
    if (reset || w_start_ok) begin
      r_first_idx <= '0;
      r_first_vld <= 1'b0;
    end else if (w_score && w_mismatch && !r_first_vld) begin
      r_first_idx <= w_cnt[CNT_W-1:0];
      r_first_vld <= 1'b1;
    end
  end

  assign first_err_idx = r_first_idx;
  assign first_err_vld = r_first_vld;
`endif

endmodule
`default_nettype wire

// File: tb/tb_viterbi_ber_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_viterbi_ber_checker
// Purpose : Three checker configurations driven in parallel against a
//           window/latency reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_viterbi_ber_checker;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset, start, ref_bit, dec_bit, dec_valid;

  logic        busy0, done0, pulse0, busy1, done1, pulse1, busy2, done2, pulse2;
  logic [15:0] err0, bits0, err2, bits2;
  logic [3:0]  err1, bits1;
`ifdef BER_FIRST_ERR_EN
  logic [15:0] fidx0, fidx2;
  logic [3:0]  fidx1;
  logic        fvld0, fvld1, fvld2;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pulses0  = 0;

  int lat_p [N] = '{32, 32, 0};
  int win_p [N] = '{16, 15, 8};
  int max_p [N] = '{65535, 15, 65535};

  bit m_active [N];
  bit m_done   [N];
  bit m_pulse  [N];
  bit m_fvld   [N];
  int m_idx    [N];
  int m_bits   [N];
  int m_errs   [N];
  int m_first  [N];

  always #5 clk = ~clk;

  viterbi_ber_checker #(.LAT(32), .WINDOW(16), .CNT_W(16)) u_dut0 (
    .clock(clk), .reset(reset), .start(start), .ref_bit(ref_bit), .dec_bit(dec_bit),
    .dec_valid(dec_valid), .busy(busy0), .done(done0), .err_pulse(pulse0),
    .err_cnt(err0), .bit_cnt(bits0)
`ifdef BER_FIRST_ERR_EN
    , .first_err_idx(fidx0), .first_err_vld(fvld0)
`endif
  );

  viterbi_ber_checker #(.LAT(32), .WINDOW(15), .CNT_W(4)) u_dut1 (
    .clock(clk), .reset(reset), .start(start), .ref_bit(ref_bit), .dec_bit(dec_bit),
    .dec_valid(dec_valid), .busy(busy1), .done(done1), .err_pulse(pulse1),
    .err_cnt(err1), .bit_cnt(bits1)
`ifdef BER_FIRST_ERR_EN
    , .first_err_idx(fidx1), .first_err_vld(fvld1)
`endif
  );

  viterbi_ber_checker #(.LAT(0), .WINDOW(8), .CNT_W(16)) u_dut2 (
    .clock(clk), .reset(reset), .start(start), .ref_bit(ref_bit), .dec_bit(dec_bit),
    .dec_valid(dec_valid), .busy(busy2), .done(done2), .err_pulse(pulse2),
    .err_cnt(err2), .bit_cnt(bits2)
`ifdef BER_FIRST_ERR_EN
    , .first_err_idx(fidx2), .first_err_vld(fvld2)
`endif
  );

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference: a measurement is 'edges since start'; edges beyond LAT with
  // dec_valid are scored until WINDOW of them have been seen.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_active[i] = 0; m_done[i] = 0; m_pulse[i] = 0; m_fvld[i] = 0;
        m_idx[i] = 0; m_bits[i] = 0; m_errs[i] = 0; m_first[i] = 0;
      end else begin
        m_pulse[i] = 0;
        if (!m_active[i]) begin
          if (start) begin
            m_active[i] = 1; m_done[i] = 0; m_fvld[i] = 0;
            m_idx[i] = 0; m_bits[i] = 0; m_errs[i] = 0; m_first[i] = 0;
          end
        end else begin
          m_idx[i]++;
          if (m_idx[i] > lat_p[i] && dec_valid) begin
            if (ref_bit != dec_bit) begin
              if (!m_fvld[i]) begin
                m_first[i] = m_bits[i];
                m_fvld[i]  = 1;
              end
              if (m_errs[i] < max_p[i]) m_errs[i]++;
              m_pulse[i] = 1;
            end
            m_bits[i]++;
            if (m_bits[i] == win_p[i]) begin
              m_active[i] = 0;
              m_done[i]   = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_inst(input int i, input int unsigned busy, input int unsigned done,
                            input int unsigned pulse, input int unsigned errc,
                            input int unsigned bitc);
    check($sformatf("u%0d busy", i), busy, m_active[i]);
    check($sformatf("u%0d done", i), done, m_done[i]);
    check($sformatf("u%0d err_pulse", i), pulse, m_pulse[i]);
    check($sformatf("u%0d err_cnt", i), errc, m_errs[i]);
    check($sformatf("u%0d bit_cnt", i), bitc, m_bits[i]);
  endtask

  task automatic check_all();
    check_inst(0, busy0, done0, pulse0, err0, bits0);
    check_inst(1, busy1, done1, pulse1, err1, bits1);
    check_inst(2, busy2, done2, pulse2, err2, bits2);
`ifdef BER_FIRST_ERR_EN
    check("u0 first_err_idx", fidx0, m_first[0]);
    check("u0 first_err_vld", fvld0, m_fvld[0]);
    check("u1 first_err_idx", fidx1, m_first[1]);
    check("u1 first_err_vld", fvld1, m_fvld[1]);
    check("u2 first_err_idx", fidx2, m_first[2]);
    check("u2 first_err_vld", fvld2, m_fvld[2]);
`endif
  endtask

  // Inputs change on the falling edge; outputs are checked one falling edge later.
  task automatic cyc(input bit s, input bit v, input bit r, input bit d);
    start = s; dec_valid = v; ref_bit = r; dec_bit = d;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (pulse0) pulses0++;
  endtask

  initial begin
    bit r;
    reset = 1'b1; start = 1'b0; ref_bit = 1'b0; dec_bit = 1'b0; dec_valid = 1'b0;
    @(negedge clk);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 0);
    reset = 1'b0;

    // Window of 16 with mismatches at bit 3 and bit 15.
    pulses0 = 0;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 32; k++) cyc(0, 1, 0, 0);
    for (int b = 0; b < 16; b++) cyc(0, 1, 0, (b == 3) || (b == 15));
    check("s1 err_cnt", err0, 2);
    check("s1 bit_cnt", bits0, 16);
    check("s1 done", done0, 1);
    check("s1 pulses", pulses0, 2);

    // Mismatches while the delay line fills are never scored.
    pulses0 = 0;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 32; k++) cyc(0, 1, 1, 0);
    for (int b = 0; b < 16; b++) begin
      r = 1'($urandom);
      cyc(0, 1, r, r);
    end
    check("s2 err_cnt", err0, 0);
    check("s2 pulses", pulses0, 0);
    check("s2 done", done0, 1);

    // Alternating valid; invalid beats carry mismatches.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 32; k++) cyc(0, 0, 0, 0);
    for (int k = 0; k < 32; k++) begin
      r = 1'($urandom);
      if (k % 2 == 0) cyc(0, 1, r, r);
      else            cyc(0, 0, 1, 0);
    end
    check("s3 bit_cnt", bits0, 16);
    check("s3 err_cnt", err0, 0);
    check("s3 done", done0, 1);

    // All mismatched on the 4-bit instance, with a start while busy.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 60; k++) cyc((k == 10) || (k == 40), 1, 1, 0);
    check("s4 err_cnt", err1, 15);
    check("s4 bit_cnt", bits1, 15);
    check("s4 done", done1, 1);
    cyc(1, 0, 0, 0);
    check("s4 restart err", err1, 0);
    check("s4 restart busy", busy1, 1);

    // First-error capture: mismatches at bits 5 and 9.
    for (int k = 0; k < 32; k++) cyc(0, 0, 0, 0);
    for (int b = 0; b < 16; b++) cyc(0, 1, 0, (b == 5) || (b == 9));
    check("s5 err_cnt", err0, 2);
`ifdef BER_FIRST_ERR_EN
    check("s5 first_err_idx", fidx0, 5);
    check("s5 first_err_vld", fvld0, 1);
`endif

    // Reset in COUNT after 10 errors, then a clean run.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 32; k++) cyc(0, 0, 0, 0);
    for (int b = 0; b < 12; b++) cyc(0, 1, 0, b < 10);
    check("s6 err before reset", err0, 10);
    reset = 1'b1;
    cyc(0, 1, 1, 0);
    reset = 1'b0;
    check("s6 busy", busy0, 0);
    check("s6 done", done0, 0);
    check("s6 err_cnt", err0, 0);
    check("s6 bit_cnt", bits0, 0);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 48; k++) cyc(0, 1, 1, 1);
    check("s6 rerun done", done0, 1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
          1'($urandom), 1'($urandom));
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
- Sits directly downstream of the 32-flop reference-bit delay line in the decoder datapath.
- Compares the delayed reference bit against the Viterbi decoder's output bit on each valid cycle and counts mismatches over a programmable measurement window.
- Reports the bit-error count and the bits-compared count to the test/status logic.

Parameters:
- LAT, 32, clock cycles to discard after start; equals the delay-line depth so its reset zeros are never scored.
- WINDOW, 1024, number of valid decoded bits compared per measurement (legal range 1..2^CNT_W-1).
- CNT_W, 16, width of the error and bit counters.

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse that begins a measurement
- ref_bit  input  1  delayed reference bit from the delay line output
- dec_bit  input  1  decoded bit from the traceback unit
- dec_valid  input  1  dec_bit/ref_bit pair is valid this cycle
- busy  output  1  measurement in progress (FILL or COUNT)
- done  output  1  level; measurement complete and results stable
- err_pulse  output  1  registered one-cycle flag for a scored mismatch
- err_cnt  output  CNT_W  mismatches counted, saturating
- bit_cnt  output  CNT_W  valid bits compared

Behaviour:
- Reset (reset=1 at a clock edge): state=IDLE. busy=0, done=0, err_pulse=0, err_cnt=0, bit_cnt=0, fill counter=0. Reset overrides every other input, including a measurement in progress.
- FSM states and transitions:
  - IDLE: on start=1, go to FILL, clear err_cnt, bit_cnt and the fill counter.
  - FILL: count clock cycles, not valid beats, because the delay line shifts every clock. Comparisons are ignored. After exactly LAT cycles in FILL, go to COUNT. If LAT=0, go straight from IDLE to COUNT.
  - COUNT: on each cycle with dec_valid=1:
    - bit_cnt increments.
    - If ref_bit != dec_bit, err_cnt increments and err_pulse=1 on the next cycle.
    - When the increment makes bit_cnt equal WINDOW, go to DONE. The last bit is scored.
    - Cycles with dec_valid=0 leave all counters unchanged.
  - DONE: done=1; err_cnt and bit_cnt hold. On start=1, clear the counters, drop done and go to FILL the following cycle.
- busy=1 exactly in FILL and COUNT. done=1 exactly in DONE. Both are registered.
- start while busy=1 is ignored; the measurement does not restart.
- err_cnt saturates at 2^CNT_W-1 and never wraps. bit_cnt cannot exceed WINDOW.
- err_pulse is 0 in IDLE, FILL and DONE, and on every non-scored cycle.
- Unsigned arithmetic throughout; the counters are CNT_W bits wide.

Optional Feature:
- Macro: BER_FIRST_ERR_EN.
- Defined:
  - Adds output first_err_idx (CNT_W bits) and output first_err_vld (1 bit).
  - On the first scored mismatch of a measurement, first_err_idx captures the bit_cnt value before the increment (0-based position) and first_err_vld is set.
  - Both are cleared by reset and by start. Later mismatches do not change them.
- Undefined: the ports and registers are absent. All other behaviour is identical.

Decomposition:
- Shared package (viterbi_pkg):
  - FSM state encoding constants: IDLE=2'd0, FILL=2'd1, COUNT=2'd2, DONE=2'd3.
  - Default CNT_W constant.
  - PIPE_DEPTH=32 constant, used as the LAT default so the checker stays matched to the delay line.
- One sub-module: sat_counter (CNT_W-wide, with synchronous clear, increment enable and saturation).
  - Instantiated twice: once for err_cnt and once for the fill/bit count.

Test Plan:
- Reset during COUNT after 10 errors -> next cycle busy=0, done=0, err_cnt=0, bit_cnt=0, state IDLE; a later start runs normally.
- LAT=32, WINDOW=16, start, dec_valid=1 continuously, ref_bit=dec_bit except bit indices 3 and 15 -> busy for 48 cycles; done=1 on cycle 49; err_cnt=2, bit_cnt=16; err_pulse high exactly twice.
- Mismatches forced during FILL (cycles 1–32) with matching bits in COUNT -> err_cnt=0, err_pulse never asserted.
- dec_valid toggling 1,0,1,0 in COUNT with WINDOW=8 -> completion takes 16 COUNT cycles; bit_cnt=8; invalid-cycle mismatches are not counted.
- CNT_W=4, WINDOW=15, all bits mismatched -> err_cnt=15 (saturates, no wrap); a second start while busy is ignored; start in DONE clears the counters and restarts.
- With BER_FIRST_ERR_EN, first mismatch at bit 5 and later at bit 9 -> first_err_idx=5, first_err_vld=1, unchanged after bit 9.
